// File: rtl/hit_timestamper.sv
// hit_timestamper: groups single-cycle hit pulses into coincidence events
// (timestamp of the first hit + channel mask) and buffers the records in a
// FIFO drained through a valid/ready interface.
//
// Optional feature macro: HIT_TS_DEADTIME_EN adds a DEAD state after every
// event close, during which hits are ignored.
//
// Ports:
//   clk          system clock
//   aresetn      asynchronous reset, active-low
//   hit          per-channel detection pulses (one cycle wide)
//   o_valid      head record valid
//   i_ready      consumer accepts head record
//   o_timestamp  timestamp of the head record
//   o_mask       channel mask of the head record
//   o_count      FIFO occupancy
//   o_overflow   saturating count of records dropped on a full FIFO
module hit_timestamper #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned TS_WIDTH = 32,
  parameter int unsigned WINDOW   = 4,
  parameter int unsigned MIN_MULT = 1,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DEADTIME = 8
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [N_CH-1:0]           hit,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [TS_WIDTH-1:0]       o_timestamp,
  output logic [N_CH-1:0]           o_mask,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [15:0]               o_overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WCW = $clog2(WINDOW + 1);
  localparam int unsigned PCW = $clog2(N_CH + 1);
  localparam int unsigned RW  = TS_WIDTH + N_CH;

`ifdef HIT_TS_DEADTIME_EN
  localparam int unsigned DTW = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DEAD} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_COLLECT} state_t;
`endif

  state_t              state, state_nxt;
  logic [TS_WIDTH-1:0] ts;
  logic [TS_WIDTH-1:0] ev_ts, ev_ts_nxt;
  logic [N_CH-1:0]     ev_mask, ev_mask_nxt;
  logic [WCW-1:0]      win_cnt, win_cnt_nxt;
  logic                close_c;
  logic [TS_WIDTH-1:0] push_ts_c;
  logic [N_CH-1:0]     push_mask_c;
  logic [PCW-1:0]      pop_cnt_c;
  logic                push_c, pop_c, full_c, wr_en_c;

`ifdef HIT_TS_DEADTIME_EN
  logic [DTW-1:0]      dead_cnt, dead_nxt;
`else
  logic                unused_deadtime;
  assign unused_deadtime = (DEADTIME != 0);
`endif

  // Event FSM: open on first hit, accumulate the mask for WINDOW cycles, close.
  always_comb begin
    state_nxt   = state;
    ev_ts_nxt   = ev_ts;
    ev_mask_nxt = ev_mask;
    win_cnt_nxt = win_cnt;
    close_c     = 1'b0;
    push_ts_c   = ev_ts;
    push_mask_c = ev_mask;
`ifdef HIT_TS_DEADTIME_EN
    dead_nxt    = dead_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (hit != '0) begin
          ev_ts_nxt   = ts;
          ev_mask_nxt = hit;
          win_cnt_nxt = WCW'(1);
          push_ts_c   = ts;
          push_mask_c = hit;
          if (WINDOW == 1) close_c = 1'b1;
          else             state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        ev_mask_nxt = ev_mask | hit;
        win_cnt_nxt = win_cnt + WCW'(1);
        push_mask_c = ev_mask | hit;
        if (win_cnt == WCW'(WINDOW - 1)) close_c = 1'b1;
      end
`ifdef HIT_TS_DEADTIME_EN
      // Hits on the DEADTIME-1 edges after close are ignored.
      S_DEAD: begin
        if (dead_cnt != '0) dead_nxt = dead_cnt - DTW'(1);
        if (dead_cnt <= DTW'(1)) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
    if (close_c) begin
`ifdef HIT_TS_DEADTIME_EN
      state_nxt = S_DEAD;
      dead_nxt  = DTW'(DEADTIME - 1);
`else
      state_nxt = S_IDLE;
`endif
    end
  end

  // Multiplicity filter on the closing mask.
  always_comb begin
    pop_cnt_c = '0;
    for (int i = 0; i < int'(N_CH); i++) pop_cnt_c = pop_cnt_c + PCW'(push_mask_c[i]);
  end

  assign push_c  = close_c && (pop_cnt_c >= PCW'(MIN_MULT));
  assign pop_c   = o_valid && i_ready;
  assign full_c  = (o_count == CW'(DEPTH));
  assign wr_en_c = push_c && (!full_c || pop_c);

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CW-1:0] count_nxt;
  logic [RW-1:0] head_nxt;

  // Next head: bypass the written record when it lands at the new read pointer.
  always_comb begin
    rd_nxt    = rd_ptr + AW'(pop_c);
    count_nxt = o_count + CW'(wr_en_c) - CW'(pop_c);
    head_nxt  = {o_timestamp, o_mask};
    if (count_nxt != '0) begin
      if (wr_en_c && (wr_ptr == rd_nxt)) head_nxt = {push_ts_c, push_mask_c};
      else                               head_nxt = mem[rd_nxt];
    end
  end

  // Record storage.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr] <= {push_ts_c, push_mask_c};
  end

  // State, timestamp, FIFO control and registered outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      ts          <= '0;
      ev_ts       <= '0;
      ev_mask     <= '0;
      win_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_count     <= '0;
      o_valid     <= 1'b0;
      o_timestamp <= '0;
      o_mask      <= '0;
      o_overflow  <= '0;
`ifdef HIT_TS_DEADTIME_EN
      dead_cnt    <= '0;
`endif
    end else begin
      state   <= state_nxt;
      ts      <= ts + TS_WIDTH'(1);
      ev_ts   <= ev_ts_nxt;
      ev_mask <= ev_mask_nxt;
      win_cnt <= win_cnt_nxt;
`ifdef HIT_TS_DEADTIME_EN
      dead_cnt <= dead_nxt;
`endif
      if (wr_en_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr                   <= rd_nxt;
      o_count                  <= count_nxt;
      o_valid                  <= (count_nxt != '0);
      {o_timestamp, o_mask}    <= head_nxt;
      if (push_c && full_c && !pop_c && (o_overflow != 16'hFFFF))
        o_overflow <= o_overflow + 16'd1;
    end
  end

endmodule

// File: tb/tb_hit_timestamper.sv
// Directed bench for hit_timestamper: one default instance (MIN_MULT=1) and
// one MIN_MULT=2 instance sharing clock and reset.
module tb_hit_timestamper;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  hit, hit2;
  logic        ready, ready2;
  logic        valid, valid2;
  logic [31:0] tsout, tsout2;
  logic [3:0]  mask, mask2;
  logic [3:0]  count, count2;
  logic [15:0] ovf, ovf2;

  int n_checks = 0;
  int n_err    = 0;
  int next_ts  = 0;

  always #5 clk = ~clk;

  hit_timestamper dut (
    .clk(clk), .aresetn(aresetn), .hit(hit), .o_valid(valid), .i_ready(ready),
    .o_timestamp(tsout), .o_mask(mask), .o_count(count), .o_overflow(ovf)
  );

  hit_timestamper #(.MIN_MULT(2)) dut2 (
    .clk(clk), .aresetn(aresetn), .hit(hit2), .o_valid(valid2), .i_ready(ready2),
    .o_timestamp(tsout2), .o_mask(mask2), .o_count(count2), .o_overflow(ovf2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // next_ts is the DUT timestamp sampled at the upcoming edge.
  task automatic tick();
    @(posedge clk);
    #1;
    next_ts++;
  endtask

  task automatic wait_to(input int t);
    while (next_ts < t) tick();
  endtask

  task automatic hit_at(input int t, input logic [3:0] m);
    wait_to(t);
    hit = m;
    tick();
    hit = '0;
  endtask

  task automatic hit2_at(input int t, input logic [3:0] m);
    wait_to(t);
    hit2 = m;
    tick();
    hit2 = '0;
  endtask

  initial begin
    aresetn = 1'b0;
    hit = '0; hit2 = '0;
    ready = 1'b0; ready2 = 1'b1;
    tick(); tick();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ts",    64'(tsout), 64'd0);
    chk("rst_mask",  64'(mask),  64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ovf",   64'(ovf),   64'd0);
    aresetn = 1'b1;
    next_ts = 0;

    // Single hit at ts=10, valid for exactly one cycle after edge 13.
    ready = 1'b1;
    hit_at(10, 4'b0010);
    chk("single_pre11", 64'(valid), 64'd0);
    tick();
    chk("single_pre12", 64'(valid), 64'd0);
    tick();
    chk("single_pre13", 64'(valid), 64'd0);
    tick();
    chk("single_valid", 64'(valid), 64'd1);
    chk("single_ts",    64'(tsout), 64'd10);
    chk("single_mask",  64'(mask),  64'b0010);
    chk("single_count", 64'(count), 64'd1);
    tick();
    chk("single_gone",  64'(valid), 64'd0);
    chk("single_cnt0",  64'(count), 64'd0);

    // Coincidence across the window edge, then a new event right after close.
    hit_at(20, 4'b0001);
    hit_at(23, 4'b1000);
    chk("coin_valid", 64'(valid), 64'd1);
    chk("coin_ts",    64'(tsout), 64'd20);
    chk("coin_mask",  64'(mask),  64'b1001);
    hit_at(24, 4'b0100);
    chk("coin_popped", 64'(valid), 64'd0);
    wait_to(28);
    chk("sep_valid", 64'(valid), 64'd1);
    chk("sep_ts",    64'(tsout), 64'd24);
    chk("sep_mask",  64'(mask),  64'b0100);
    tick();
    chk("sep_gone",  64'(valid), 64'd0);

    // MIN_MULT=2 instance: lone hit discarded, pair kept.
    hit2_at(40, 4'b0010);
    wait_to(46);
    chk("mm_lone_count", 64'(count2), 64'd0);
    chk("mm_lone_valid", 64'(valid2), 64'd0);
    hit2_at(50, 4'b0010);
    hit2_at(52, 4'b0100);
    wait_to(54);
    chk("mm_pair_valid", 64'(valid2), 64'd1);
    chk("mm_pair_mask",  64'(mask2),  64'b0110);
    chk("mm_pair_ts",    64'(tsout2), 64'd50);
    chk("mm_dut1_idle",  64'(count),  64'd0);

    // Fill with i_ready low: 10 events into depth 8.
    ready = 1'b0;
    for (int k = 0; k < 10; k++) hit_at(60 + 6 * k, 4'(k + 1));
    wait_to(118);
    chk("full_count", 64'(count), 64'd8);
    chk("full_ovf",   64'(ovf),   64'd2);
    chk("full_valid", 64'(valid), 64'd1);
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", 64'(valid), 64'd1);
      chk("drain_ts",    64'(tsout), 64'(60 + 6 * k));
      chk("drain_mask",  64'(mask),  64'(k + 1));
      tick();
    end
    ready = 1'b0;
    chk("drain_empty", 64'(valid), 64'd0);
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_ovf",   64'(ovf),   64'd2);

    // Refill, then push and pop on the same edge while full.
    for (int k = 0; k < 8; k++) hit_at(130 + 6 * k, 4'(k + 1));
    wait_to(177);
    chk("refill_count", 64'(count), 64'd8);
    hit_at(180, 4'b1111);
    wait_to(183);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("pp_count", 64'(count), 64'd8);
    chk("pp_ovf",   64'(ovf),   64'd2);
    chk("pp_head",  64'(tsout), 64'd136);
    ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      chk("pp_drain_ts",   64'(tsout), 64'(130 + 6 * k));
      chk("pp_drain_mask", 64'(mask),  64'(k + 1));
      tick();
    end
    chk("pp_last_ts",   64'(tsout), 64'd180);
    chk("pp_last_mask", 64'(mask),  64'b1111);
    tick();
    chk("pp_empty", 64'(count), 64'd0);
    ready = 1'b0;

    // Reset in the middle of COLLECT with 3 records buffered.
    hit_at(200, 4'b0001);
    hit_at(206, 4'b0010);
    hit_at(212, 4'b0100);
    wait_to(216);
    chk("pre_rst_count", 64'(count), 64'd3);
    hit_at(220, 4'b1000);
    aresetn = 1'b0;
    tick(); tick();
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_ts",    64'(tsout), 64'd0);
    chk("mid_rst_mask",  64'(mask),  64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_ovf",   64'(ovf),   64'd0);
    aresetn = 1'b1;
    next_ts = 0;
    wait_to(4);
    chk("post_rst_count", 64'(count), 64'd0);
    hit_at(5, 4'b0011);
    wait_to(9);
    chk("post_rst_valid", 64'(valid), 64'd1);
    chk("post_rst_ts",    64'(tsout), 64'd5);
    chk("post_rst_mask",  64'(mask),  64'b0011);
    chk("post_rst_cnt",   64'(count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
